// File: rtl/cdb_arbiter_if.sv
// Producer and CDB signal bundle for the CDB arbiter.
// Master is the producer/snooper side, slave is the arbiter.
interface cdb_arbiter_if #(
    parameter int TAG_WIDTH  = 4,
    parameter int DATA_WIDTH = 32
);
    logic                  alu_valid_in;
    logic [TAG_WIDTH-1:0]  alu_tag_in;
    logic [DATA_WIDTH-1:0] alu_result_in;
    logic                  alu_ready_out;

    logic                  lsb_valid_in;
    logic [TAG_WIDTH-1:0]  lsb_tag_in;
    logic [DATA_WIDTH-1:0] lsb_result_in;
    logic                  lsb_ready_out;

    logic                  cdb_valid_out;
    logic [TAG_WIDTH-1:0]  cdb_tag_out;
    logic [DATA_WIDTH-1:0] cdb_result_out;
    logic                  cdb_src_out;

    modport master (
        output alu_valid_in, alu_tag_in, alu_result_in,
        output lsb_valid_in, lsb_tag_in, lsb_result_in,
        input  alu_ready_out, lsb_ready_out,
        input  cdb_valid_out, cdb_tag_out, cdb_result_out, cdb_src_out
    );

    modport slave (
        input  alu_valid_in, alu_tag_in, alu_result_in,
        input  lsb_valid_in, lsb_tag_in, lsb_result_in,
        output alu_ready_out, lsb_ready_out,
        output cdb_valid_out, cdb_tag_out, cdb_result_out, cdb_src_out
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two result FIFOs (ALU, LSB) drained
// round-robin onto a registered CDB; flushed by rst or rollback.
module cdb_arbiter #(
    parameter int TAG_WIDTH  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rollback_in,
    cdb_arbiter_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef logic [PW-1:0]         ptr_t;
    typedef logic [CW-1:0]         cnt_t;
    typedef logic [TAG_WIDTH-1:0]  tag_t;
    typedef logic [DATA_WIDTH-1:0] dat_t;

    // Index 0 is the ALU FIFO, index 1 the LSB FIFO.
    tag_t tag_mem_q [2][DEPTH];
    dat_t dat_mem_q [2][DEPTH];

    ptr_t wr_ptr_q [2];
    ptr_t wr_ptr_d [2];
    ptr_t rd_ptr_q [2];
    ptr_t rd_ptr_d [2];
    cnt_t cnt_q    [2];
    cnt_t cnt_d    [2];

    logic last_q, last_d;
    logic cdb_v_q, cdb_v_d;
    tag_t cdb_tag_q, cdb_tag_d;
    dat_t cdb_res_q, cdb_res_d;
    logic cdb_src_q, cdb_src_d;

    logic       flush;
    logic [1:0] in_valid;
    tag_t       in_tag [2];
    dat_t       in_dat [2];
    logic [1:0] nonempty;
    logic [1:0] ready;
    logic [1:0] push;
    logic [1:0] pop;
    logic       grant_v;
    logic       win;

    assign flush     = rst | rollback_in;
    assign in_valid  = {bus.lsb_valid_in, bus.alu_valid_in};
    assign in_tag[0] = bus.alu_tag_in;
    assign in_tag[1] = bus.lsb_tag_in;
    assign in_dat[0] = bus.alu_result_in;
    assign in_dat[1] = bus.lsb_result_in;

    // Handshake: a full FIFO refuses input even while it pops.
    always_comb begin
        nonempty = '0;
        ready    = '0;
        for (int s = 0; s < 2; s++) begin
            nonempty[s] = (cnt_q[s] != '0);
            ready[s]    = (cnt_q[s] < cnt_t'(DEPTH)) && !flush;
        end
        push = in_valid & ready;
    end

    // Round-robin pick over the registered FIFO heads.
    always_comb begin
        grant_v = |nonempty;
        win     = (&nonempty) ? ~last_q : nonempty[1];
        pop     = '0;
        if (grant_v && !flush) begin
            pop[win] = 1'b1;
        end
    end

    // Next-state for pointers, counts, last grant and CDB.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            wr_ptr_d[s] = wr_ptr_q[s] + ptr_t'(push[s]);
            rd_ptr_d[s] = rd_ptr_q[s] + ptr_t'(pop[s]);
            cnt_d[s]    = cnt_q[s] + cnt_t'(push[s])
                        - cnt_t'(pop[s]);
        end
        last_d    = last_q;
        cdb_v_d   = 1'b0;
        cdb_tag_d = '0;
        cdb_res_d = '0;
        cdb_src_d = 1'b0;
        if (flush) begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_d[s] = '0;
                rd_ptr_d[s] = '0;
                cnt_d[s]    = '0;
            end
            last_d = 1'b1;
        end else if (grant_v) begin
            last_d    = win;
            cdb_v_d   = 1'b1;
            cdb_tag_d = tag_mem_q[win][rd_ptr_q[win]];
            cdb_res_d = dat_mem_q[win][rd_ptr_q[win]];
            cdb_src_d = win;
        end
    end

    // Control state register; flushing is folded into the _d logic.
    always_ff @(posedge clk) begin
        wr_ptr_q  <= wr_ptr_d;
        rd_ptr_q  <= rd_ptr_d;
        cnt_q     <= cnt_d;
        last_q    <= last_d;
        cdb_v_q   <= cdb_v_d;
        cdb_tag_q <= cdb_tag_d;
        cdb_res_q <= cdb_res_d;
        cdb_src_q <= cdb_src_d;
    end

    // FIFO storage write at the tail on an accepted handshake.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                tag_mem_q[s][wr_ptr_q[s]] <= in_tag[s];
                dat_mem_q[s][wr_ptr_q[s]] <= in_dat[s];
            end
        end
    end

    assign bus.alu_ready_out  = ready[0];
    assign bus.lsb_ready_out  = ready[1];
    assign bus.cdb_valid_out  = cdb_v_q;
    assign bus.cdb_tag_out    = cdb_tag_q;
    assign bus.cdb_result_out = cdb_res_q;
    assign bus.cdb_src_out    = cdb_src_q;
endmodule
